iiitb_r2_4bit_div: RTL and testbench

- Sequential radix-2 non-restoring unsigned divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.
- Inverse datapath of the team's 4-bit Booth multiplier: an 8-bit product can be divided by one operand to recover the other.
- One quotient bit per clock, with a load/busy/done handshake.
- Sits beside the multiplier in the arithmetic unit.

---
 rtl/iiitb_r2_4bit_div.sv | 125 ++++++++++++
 tb/tb_iiitb_r2_4bit_div.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_r2_4bit_div.sv
`default_nettype none
// ============================================================================
// Module   : iiitb_r2_4bit_div
// Purpose  : Sequential radix-2 non-restoring unsigned divider, 2W / W bits.
// Revision : 1.0
// ============================================================================
module iiitb_r2_4bit_div #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [2*WIDTH-1:0] N,
  input  logic [WIDTH-1:0]   D,
  output logic [WIDTH-1:0]   Quo,
  output logic [WIDTH-1:0]   Rem,
  output logic               busy,
  output logic               done,
  output logic               dbz,
  output logic               ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic             r_ovf;

  logic [WIDTH:0]   w_d_ext;
  logic [WIDTH:0]   w_a_shl;
  logic [WIDTH:0]   w_a_step;
  logic [WIDTH:0]   w_a_fix;
  logic             w_ovf;

  assign w_d_ext  = {1'b0, r_d};
  assign w_a_shl  = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  // Sign of the partial remainder before the shift picks add versus subtract.
  assign w_a_step = r_a[WIDTH] ? (w_a_shl + w_d_ext) : (w_a_shl - w_d_ext);
  assign w_a_fix  = r_a[WIDTH] ? (r_a + w_d_ext) : r_a;
  assign w_ovf    = (N[2*WIDTH-1:WIDTH] >= D);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
            if (D == '0) begin
              r_dbz  <= 1'b1;
              r_quo  <= '1;
              r_rem  <= '0;
              r_done <= 1'b1;
            end else if (w_ovf) begin
              r_ovf  <= 1'b1;
              r_quo  <= '1;
              r_rem  <= '0;
              r_done <= 1'b1;
            end else begin
              r_a     <= {1'b0, N[2*WIDTH-1:WIDTH]};
              r_q     <= N[WIDTH-1:0];
              r_d     <= D;
              r_cnt   <= CW'(WIDTH);
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_a   <= w_a_step;
          r_q   <= {r_q[WIDTH-2:0], ~w_a_step[WIDTH]};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_a     <= w_a_fix;
          r_quo   <= r_q;
          r_rem   <= w_a_fix[WIDTH-1:0];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Quo  = r_quo;
  assign Rem  = r_rem;
  assign busy = r_busy;
  assign done = r_done;
  assign dbz  = r_dbz;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_iiitb_r2_4bit_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_iiitb_r2_4bit_div
// Purpose  : Scoreboard bench for the radix-2 non-restoring divider.
// Revision : 1.0
// ============================================================================
module tb_iiitb_r2_4bit_div;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] N;
  logic [3:0] D;
  logic [3:0] Quo;
  logic [3:0] Rem;
  logic       busy;
  logic       done;
  logic       dbz;
  logic       ovf;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] n;
    logic [3:0] d;
    logic [3:0] quo;
    logic [3:0] rem;
    logic       dbz;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  iiitb_r2_4bit_div #(.WIDTH(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .N     (N),
    .D     (D),
    .Quo   (Quo),
    .Rem   (Rem),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] n, input logic [3:0] d);
    exp_t e;
    e.n = n;
    e.d = d;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (d == 4'd0) begin
      e.dbz = 1'b1;
      e.quo = 4'hF;
      e.rem = 4'h0;
    end else if (n[7:4] >= d) begin
      e.ovf = 1'b1;
      e.quo = 4'hF;
      e.rem = 4'h0;
    end else begin
      e.quo = 4'(n / 8'(d));
      e.rem = 4'(n % 8'(d));
    end
    return e;
  endfunction

  // Result monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quo", 32'(Quo), 32'(e.quo));
        chk("rem", 32'(Rem), 32'(e.rem));
        chk("dbz", 32'(dbz), 32'(e.dbz));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        if (!e.dbz && !e.ovf) begin
          chk("invariant", 32'(Quo) * 32'(e.d) + 32'(Rem), 32'(e.n));
          chk("rem_lt_d", 32'(32'(Rem) < 32'(e.d)), 32'd1);
        end
      end
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
  endtask

  // Called at a negedge; returns at the negedge where done is observed high.
  task automatic do_op(input logic [7:0] n, input logic [3:0] d);
    exp_t e;
    int   cyc;
    int   rest;
    logic err;
    e = model(n, d);
    err = e.dbz | e.ovf;
    N = n;
    D = d;
    load = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    load = 1'b0;
    chk("busy", 32'(busy), err ? 32'd0 : 32'd1);
    wait_done(rest);
    cyc = rest + 1;
    chk("latency", 32'(cyc), err ? 32'd1 : 32'd6);
  endtask

  initial begin
    int cyc;
    reset = 1'b0;
    load  = 1'b0;
    N     = 8'd0;
    D     = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_quo",  32'(Quo),  32'd0);
    chk("rst_rem",  32'(Rem),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz",  32'(dbz),  32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    reset = 1'b1;
    @(negedge clk);

    do_op(8'd100, 4'd7);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);

    do_op(8'd143, 4'd11);
    do_op(8'd0,   4'd5);
    do_op(8'd45,  4'd3);
    do_op(8'd12,  4'd0);
    do_op(8'd80,  4'd5);
    @(negedge clk);
    chk("flag_hold_ovf", 32'(ovf), 32'd1);

    // A load while busy is ignored; a load in the done cycle is taken.
    N = 8'd100; D = 4'd7; load = 1'b1;
    sb.push_back(model(8'd100, 4'd7));
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    N = 8'd9; D = 4'd2; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_done(cyc);
    do_op(8'd9, 4'd2);

    // Reset during the third RUN cycle aborts without a done pulse.
    @(negedge clk);
    N = 8'd100; D = 4'd7; load = 1'b1;
    sb.push_back(model(8'd100, 4'd7));
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sb.delete();
    chk("abort_quo",  32'(Quo),  32'd0);
    chk("abort_rem",  32'(Rem),  32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dbz",  32'(dbz),  32'd0);
    chk("abort_ovf",  32'(ovf),  32'd0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    do_op(8'd100, 4'd7);

    for (int n = 0; n < 256; n++) begin
      for (int d = 0; d < 16; d++) begin
        do_op(8'(n), 4'(d));
      end
    end
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
